// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port synchronous memory between fetch and execute ports.
// Define MEM_ARB_RR_EN to replace DM priority + starvation guard with round-robin.
module mem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req_valid,
  input  logic [ADDR_W-1:0] if_req_addr,
  output logic              if_req_ready,
  output logic              if_rsp_valid,
  output logic [DATA_W-1:0] if_rsp_data,
  input  logic              dm_req_valid,
  input  logic              dm_req_we,
  input  logic [ADDR_W-1:0] dm_req_addr,
  input  logic [DATA_W-1:0] dm_req_wdata,
  output logic              dm_req_ready,
  output logic              dm_rsp_valid,
  output logic [DATA_W-1:0] dm_rsp_data,
  input  logic              flush,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  state_t state_q, state_d;
  logic owner_q, we_q, drop_q, drop_d, if_vld_q, dm_vld_q, pri_dm, gnt_if, gnt_dm;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q, if_data_q, dm_data_q;
  // Readies are gated by rst_n so they read 0 while reset is held
  assign gnt_dm = rst_n && state_q == IDLE && dm_req_valid && (!if_req_valid || pri_dm);
  assign gnt_if = rst_n && state_q == IDLE && if_req_valid && !gnt_dm;
`ifdef MEM_ARB_RR_EN
  logic last_q, last_d;
  assign pri_dm = !last_q;
  assign last_d = gnt_if ? 1'b0 : gnt_dm ? 1'b1 : last_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) last_q <= 1'b0;
    else last_q <= last_d;
`else
  localparam logic [3:0] SMAX = 4'(STARVE_MAX);
  logic [3:0] starve_q, starve_d;
  assign pri_dm = starve_q != SMAX;
  assign starve_d = gnt_if ? 4'd0 :
                    (gnt_dm && if_req_valid && starve_q != SMAX) ? starve_q + 4'd1 : starve_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) starve_q <= 4'd0;
    else starve_q <= starve_d;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state_q <= IDLE;
    else state_q <= state_d;
  always_comb begin
    state_d = state_q == IDLE  ? ((gnt_if || gnt_dm) ? ISSUE : IDLE) :
              state_q == ISSUE ? WAIT :
              state_q == WAIT  ? RESP : IDLE;
  end
  always_comb begin
    if_req_ready = gnt_if;
    dm_req_ready = gnt_dm;
    mem_en       = state_q == ISSUE;
    mem_we       = state_q == ISSUE && we_q;
    mem_addr     = addr_q;
    mem_wdata    = wdata_q;
    if_rsp_valid = if_vld_q;
    if_rsp_data  = if_data_q;
    dm_rsp_valid = dm_vld_q;
    dm_rsp_data  = dm_data_q;
  end
  // A flush seen at accept or any time up to WAIT kills the fetch response
  assign drop_d = state_q == IDLE ? (gnt_if && flush) : (drop_q || flush);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      owner_q   <= 1'b0;
      we_q      <= 1'b0;
      drop_q    <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      if_vld_q  <= 1'b0;
      dm_vld_q  <= 1'b0;
      if_data_q <= '0;
      dm_data_q <= '0;
    end else begin
      drop_q   <= drop_d;
      if_vld_q <= state_q == WAIT && !owner_q && !(drop_q || flush);
      dm_vld_q <= state_q == WAIT && owner_q;
      if (gnt_if || gnt_dm) begin
        owner_q <= gnt_dm;
        we_q    <= gnt_dm && dm_req_we;
        addr_q  <= gnt_dm ? dm_req_addr : if_req_addr;
        wdata_q <= gnt_dm ? dm_req_wdata : '0;
      end
      if (state_q == WAIT && !owner_q && !(drop_q || flush)) if_data_q <= mem_rdata;
      if (state_q == WAIT && owner_q) dm_data_q <= we_q ? '0 : mem_rdata;
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: randomized bench for mem_arbiter against a transaction-level reference model.
module tb_mem_arbiter;
  localparam int STARVE_MAX = 4;
  logic clk, rst_n;
  logic if_req_valid, if_req_ready, if_rsp_valid;
  logic [31:0] if_req_addr, if_rsp_data;
  logic dm_req_valid, dm_req_we, dm_req_ready, dm_rsp_valid;
  logic [31:0] dm_req_addr, dm_req_wdata, dm_rsp_data;
  logic flush, mem_en, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [31:0] tbmem [32];
  logic [31:0] refmem [32];
  int passed = 0, total = 0, cyc = 0, next_free = 0, starve = 0;
  bit last_dm = 0, acc_if, acc_dm;
  bit tx_act = 0, tx_dm, tx_we, tx_drop;
  int tx_n;
  logic [31:0] tx_addr, tx_wdata, tx_rdata;
  logic [31:0] exp_addr = 0, exp_if_data = 0, exp_dm_data = 0;
  bit grants [$];

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req_valid(if_req_valid), .if_req_addr(if_req_addr), .if_req_ready(if_req_ready),
    .if_rsp_valid(if_rsp_valid), .if_rsp_data(if_rsp_data),
    .dm_req_valid(dm_req_valid), .dm_req_we(dm_req_we), .dm_req_addr(dm_req_addr),
    .dm_req_wdata(dm_req_wdata), .dm_req_ready(dm_req_ready),
    .dm_rsp_valid(dm_rsp_valid), .dm_rsp_data(dm_rsp_data),
    .flush(flush), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  always @(posedge clk)
    if (mem_en) begin
      if (mem_we) tbmem[mem_addr[6:2]] <= mem_wdata;
      else mem_rdata <= tbmem[mem_addr[6:2]];
    end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
  endtask

  function automatic logic [31:0] raddr();
    logic [4:0] w = 5'($urandom_range(0, 31));
    return {25'd0, w, 2'b00};
  endfunction

  task automatic model_step();
    bit e_if, e_dm, en, pri;
    bit idle = cyc >= next_free;
`ifdef MEM_ARB_RR_EN
    pri = !last_dm;
`else
    pri = starve != STARVE_MAX;
`endif
    e_dm = idle && dm_req_valid && (!if_req_valid || pri);
    e_if = idle && if_req_valid && !e_dm;
    check("if_ready", if_req_ready, e_if);
    check("dm_ready", dm_req_ready, e_dm);
    en = tx_act && cyc == tx_n + 1;
    if (en) exp_addr = tx_addr;
    check("mem_en", mem_en, en);
    check("mem_we", mem_we, en && tx_we);
    check("mem_addr", mem_addr, exp_addr);
    if (en && tx_we) check("mem_wdata", mem_wdata, tx_wdata);
    if (tx_act && !tx_dm && flush && cyc >= tx_n + 1 && cyc <= tx_n + 2) tx_drop = 1;
    if (tx_act && cyc == tx_n + 3) begin
      if (tx_dm) exp_dm_data = tx_rdata;
      else if (!tx_drop) exp_if_data = tx_rdata;
    end
    check("if_rsp_valid", if_rsp_valid, tx_act && !tx_dm && !tx_drop && cyc == tx_n + 3);
    check("dm_rsp_valid", dm_rsp_valid, tx_act && tx_dm && cyc == tx_n + 3);
    check("if_rsp_data", if_rsp_data, exp_if_data);
    check("dm_rsp_data", dm_rsp_data, exp_dm_data);
    acc_if = e_if;
    acc_dm = e_dm;
    if (e_if || e_dm) begin
      tx_act = 1; tx_n = cyc; tx_dm = e_dm; tx_we = e_dm && dm_req_we;
      tx_addr = e_dm ? dm_req_addr : if_req_addr;
      tx_wdata = dm_req_wdata;
      tx_drop = e_if && flush;
      tx_rdata = tx_we ? 32'd0 : refmem[tx_addr[6:2]];
      if (tx_we) refmem[tx_addr[6:2]] = tx_wdata;
      next_free = cyc + 4;
      if (e_if) starve = 0;
      else if (if_req_valid && starve < STARVE_MAX) starve++;
      last_dm = e_dm;
      grants.push_back(e_dm);
    end
    cyc++;
  endtask

  task automatic cycle();
    #1 model_step();
    @(negedge clk);
  endtask

  task automatic reset_phase();
    rst_n = 0;
    #1;
    check("rst_if_ready", if_req_ready, 0);
    check("rst_dm_ready", dm_req_ready, 0);
    check("rst_if_rsp_valid", if_rsp_valid, 0);
    check("rst_if_rsp_data", if_rsp_data, 0);
    check("rst_dm_rsp_valid", dm_rsp_valid, 0);
    check("rst_dm_rsp_data", dm_rsp_data, 0);
    check("rst_mem_en", mem_en, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    tx_act = 0; starve = 0; last_dm = 0;
    exp_addr = 0; exp_if_data = 0; exp_dm_data = 0;
    @(negedge clk); cyc++;
    @(negedge clk); cyc++;
    rst_n = 1;
    next_free = cyc;
  endtask

  task automatic if_op(input logic [31:0] a, input int flush_k, output int n);
    n = 0;
    if_req_valid = 1; if_req_addr = a;
    do begin cycle(); n++; end while (!acc_if && n < 20);
    check("if_accept", acc_if, 1);
    if_req_valid = 0;
    for (int k = 1; k <= 3; k++) begin
      flush = k == flush_k;
      cycle();
    end
    flush = 0;
  endtask

  task automatic dm_op(input bit we, input logic [31:0] a, input logic [31:0] wd, output int n);
    n = 0;
    dm_req_valid = 1; dm_req_we = we; dm_req_addr = a; dm_req_wdata = wd;
    do begin cycle(); n++; end while (!acc_dm && n < 20);
    check("dm_accept", acc_dm, 1);
    dm_req_valid = 0;
    repeat (3) cycle();
  endtask

  initial begin
    int n;
    rst_n = 0; flush = 0;
    if_req_valid = 0; if_req_addr = 0;
    dm_req_valid = 0; dm_req_we = 0; dm_req_addr = 0; dm_req_wdata = 0;
    for (int i = 0; i < 32; i++) refmem[i] = 0;
    @(negedge clk);
    reset_phase();
    repeat (10) cycle();
    for (int i = 0; i < 32; i++)
      dm_op(1, 32'(i * 4), (i == 4) ? 32'hDEADBEEF : $urandom, n);
    if_op(32'h10, 0, n);
    check("if_read_deadbeef", if_rsp_data, 32'hDEADBEEF);
    dm_op(1, 32'h20, 32'h12345678, n);
    check("dm_write_ack_data", dm_rsp_data, 32'h0);
    dm_op(0, 32'h20, 32'h0, n);
    check("dm_read_back", dm_rsp_data, 32'h12345678);
    check("dm_read_first_try", n, 1);
    if_op(32'h08, 2, n);
    if_op(32'h0C, 0, n);
    check("if_accept_after_flush_n4", n, 1);
    check("if_data_after_flush", if_rsp_data, refmem[3]);
    reset_phase();
    grants.delete();
    if_req_valid = 1; if_req_addr = raddr();
    dm_req_valid = 1; dm_req_we = 0; dm_req_addr = raddr();
    for (int k = 0; k < 80 && grants.size() < 10; k++) begin
      cycle();
      if (acc_if) if_req_addr = raddr();
      if (acc_dm) dm_req_addr = raddr();
    end
    if_req_valid = 0; dm_req_valid = 0;
    repeat (4) cycle();
    check("grant_count", 32'(grants.size() >= 10), 1);
    for (int k = 0; k < 10 && k < grants.size(); k++)
`ifdef MEM_ARB_RR_EN
      check("grant_order", grants[k], (k % 2 == 1) ? 0 : 1);
`else
      check("grant_order", grants[k], (k % 5 == 4) ? 0 : 1);
`endif
    dm_req_valid = 1; dm_req_we = 0; dm_req_addr = 32'h20;
    do begin cycle(); n++; end while (!acc_dm && n < 40);
    check("dm_accept_pre_rst", acc_dm, 1);
    dm_req_valid = 0;
    cycle();
    reset_phase();
    if_op(32'h14, 0, n);
    check("if_accept_after_rst", n, 1);
    for (int t = 0; t < 1500; t++) begin
      if (!if_req_valid && $urandom_range(0, 2) == 0) begin
        if_req_valid = 1; if_req_addr = raddr();
      end
      if (!dm_req_valid && $urandom_range(0, 2) == 0) begin
        dm_req_valid = 1; dm_req_we = 1'($urandom_range(0, 1));
        dm_req_addr = raddr(); dm_req_wdata = $urandom;
      end
      flush = $urandom_range(0, 9) == 0;
      cycle();
      if (acc_if) if_req_valid = 0;
      if (acc_dm) dm_req_valid = 0;
      if (tx_act && tx_dm && !tx_we && cyc == tx_n + 2 && $urandom_range(0, 7) == 0) reset_phase();
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
